// File: rtl/lsu_ctrl_pkg.sv
// Shared constants for the load/store controller: RISC-V funct3 codes,
// fault cause encodings, access-size codes and FSM state encoding.
package lsu_ctrl_pkg;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access size taken from funct3[1:0]
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // fault_cause encodings
    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane extraction and sign/zero extension.
// Ports:
//   mem_rdata  in  32  raw word from memory
//   offset     in  2   byte offset within the word
//   funct3     in  3   load width/sign code
//   load_data  out 32  extended load result
module lsu_load_align
    import lsu_ctrl_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = mem_rdata[{offset, 3'b000} +: 8];
    // Halfwords are only ever legal at offset 0 or 2, so offset[1] picks the lane.
    assign half_sel = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_data = mem_rdata;
        case (funct3)
            F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  load_data = {24'd0, byte_sel};
            F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  load_data = {16'd0, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller between execute stage and data memory.
// Accepts one load/store, checks legality/alignment, issues a word-addressed
// memory request with byte enables, waits for mem_ack (with timeout), then
// returns extended load data with a one-cycle done pulse.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   valid_i, mr, mw, funct3         pipeline request and access type
//   address, rd2                    byte address and store data
//   stall, done                     pipeline hold and completion pulse
//   load_data, fault, fault_cause   registered result, held until next accept
//   mem_req, mem_we, mem_addr,
//   mem_be, mem_wdata               memory request, stable until mem_ack
//   mem_rdata, mem_ack              memory response
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic              mr,
    input  logic              mw,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       rd2,
    output logic              stall,
    output logic              done,
    output logic [31:0]       load_data,
    output logic              fault,
    output logic [1:0]        fault_cause,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [1:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        f3_q, f3_d;
    logic              we_q, we_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       load_data_q, load_data_d;
    logic              fault_q, fault_d;
    logic [1:0]        cause_q, cause_d;

    logic        accept;
    logic        illegal;
    logic        misaligned;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] aligned_data;
    logic        timeout_hit;

    assign accept = (state_q == ST_IDLE) && valid_i && (mr || mw);

    always_comb begin
        illegal = 1'b0;
        if (mr && mw) begin
            illegal = 1'b1;
        end else if (mw) begin
            illegal = !(funct3 inside {F3_SB, F3_SH, F3_SW});
        end else begin
            illegal = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        end
    end

    always_comb begin
        misaligned = 1'b0;
        be_new     = 4'b1111;
        wdata_new  = rd2;
        case (funct3[1:0])
            SZ_BYTE: begin
                be_new    = 4'b0001 << address[1:0];
                wdata_new = {4{rd2[7:0]}};
            end
            SZ_HALF: begin
                misaligned = address[0];
                be_new     = 4'b0011 << address[1:0];
                wdata_new  = {2{rd2[15:0]}};
            end
            SZ_WORD: begin
                misaligned = (address[1:0] != 2'b00);
            end
            default: ;
        endcase
    end

    lsu_load_align u_load_align (
        .mem_rdata (mem_rdata),
        .offset    (off_q),
        .funct3    (f3_q),
        .load_data (aligned_data)
    );

    // Fires in the BUSY cycle whose count would reach TIMEOUT, so mem_req is
    // held for exactly TIMEOUT cycles.
    assign timeout_hit = (8'(cnt_q + 8'd1) == TIMEOUT_CNT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        f3_d        = f3_q;
        we_d        = we_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        load_data_d = load_data_q;
        fault_d     = fault_q;
        cause_d     = cause_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    off_d       = address[1:0];
                    f3_d        = funct3;
                    we_d        = mw;
                    mem_addr_d  = address[ADDR_W-1:2];
                    mem_be_d    = be_new;
                    mem_wdata_d = wdata_new;
                    load_data_d = 32'd0;
                    cnt_d       = 8'd0;
                    if (illegal || misaligned) begin
                        fault_d = 1'b1;
                        cause_d = illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
                        state_d = ST_RESP;
                    end else begin
                        fault_d   = 1'b0;
                        cause_d   = CAUSE_NONE;
                        mem_req_d = 1'b1;
                        state_d   = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    load_data_d = we_q ? 32'd0 : aligned_data;
                    mem_req_d   = 1'b0;
                    state_d     = ST_RESP;
                end else if (timeout_hit) begin
                    mem_req_d = 1'b0;
                    fault_d   = 1'b1;
                    cause_d   = CAUSE_TIMEOUT;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            off_q       <= 2'd0;
            f3_q        <= 3'd0;
            we_q        <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
            load_data_q <= 32'd0;
            fault_q     <= 1'b0;
            cause_q     <= CAUSE_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            f3_q        <= f3_d;
            we_q        <= we_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            load_data_q <= load_data_d;
            fault_q     <= fault_d;
            cause_q     <= cause_d;
        end
    end

    assign stall       = (state_q == ST_BUSY) || accept;
    assign done        = (state_q == ST_RESP);
    assign load_data   = load_data_q;
    assign fault       = fault_q;
    assign fault_cause = cause_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_be      = mem_be_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, mr, mw;
    logic [2:0]  funct3;
    logic [31:0] address, rd2;
    logic        stall, done, fault;
    logic [31:0] load_data;
    logic [1:0]  fault_cause;
    logic        mem_req, mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_ack;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        fault;
        logic [1:0]  cause;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ld;
    } exp_t;

    lsu_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_i     (valid_i),
        .mr          (mr),
        .mw          (mw),
        .funct3      (funct3),
        .address     (address),
        .rd2         (rd2),
        .stall       (stall),
        .done        (done),
        .load_data   (load_data),
        .fault       (fault),
        .fault_cause (fault_cause),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: derived from access size in bytes and plain arithmetic.
    function automatic exp_t model(input logic m_mr, input logic m_mw, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] sdata,
                                   input logic [31:0] rdata);
        exp_t        e;
        int          nb, off;
        logic        ill, mis;
        logic [31:0] mask, v;
        nb  = 1 << f3[1:0];
        off = int'(addr[1:0]);
        ill = (m_mr && m_mw) || (m_mw && f3 > 3'd2) ||
              (m_mr && !m_mw && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}));
        mis = !ill && ((off % nb) != 0);
        e.fault = ill || mis;
        e.cause = ill ? 2'b10 : (mis ? 2'b01 : 2'b00);
        e.be    = 4'(((1 << nb) - 1) << off);
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = sdata[8*(i % nb) +: 8];
        e.ld = 32'd0;
        if (!e.fault && m_mr) begin
            mask = (nb >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
            v    = (rdata >> (8 * off)) & mask;
            if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~mask;
            e.ld = v;
        end
        return e;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
        chk({tag, "_cause"}, {30'd0, fault_cause}, 32'd0);
        chk({tag, "_ld"}, load_data, 32'd0);
        chk({tag, "_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_be"}, {28'd0, mem_be}, 32'd0);
        chk({tag, "_addr"}, {2'd0, mem_addr}, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
    endtask

    // One full transaction; lat = BUSY cycles without ack before the ack cycle.
    task automatic run_txn(input logic t_mr, input logic t_mw, input logic [2:0] t_f3,
                           input logic [31:0] t_addr, input logic [31:0] t_rd2,
                           input logic [31:0] t_rdata, input int lat);
        exp_t e;
        e = model(t_mr, t_mw, t_f3, t_addr, t_rd2, t_rdata);
        @(negedge clk);
        valid_i = 1'b1; mr = t_mr; mw = t_mw; funct3 = t_f3; address = t_addr; rd2 = t_rd2;
        #1;
        chk("accept_stall", {31'd0, stall}, 32'd1);
        chk("accept_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        if (e.fault) begin
            chk("flt_done", {31'd0, done}, 32'd1);
            chk("flt_req", {31'd0, mem_req}, 32'd0);
            chk("flt_stall", {31'd0, stall}, 32'd0);
            chk("flt_fault", {31'd0, fault}, 32'd1);
            chk("flt_cause", {30'd0, fault_cause}, {30'd0, e.cause});
            chk("flt_ld", load_data, 32'd0);
        end else begin
            chk("req", {31'd0, mem_req}, 32'd1);
            chk("req_stall", {31'd0, stall}, 32'd1);
            chk("req_done", {31'd0, done}, 32'd0);
            chk("req_addr", {2'd0, mem_addr}, t_addr >> 2);
            chk("req_we", {31'd0, mem_we}, {31'd0, t_mw});
            chk("req_be", {28'd0, mem_be}, {28'd0, e.be});
            chk("req_wdata", mem_wdata, e.wdata);
            for (int i = 0; i < lat; i++) begin
                mem_ack = 1'b0; mem_rdata = $urandom;
                @(negedge clk);
                chk("hold_req", {31'd0, mem_req}, 32'd1);
                chk("hold_be", {28'd0, mem_be}, {28'd0, e.be});
                chk("hold_done", {31'd0, done}, 32'd0);
            end
            mem_ack = 1'b1; mem_rdata = t_rdata;
            @(negedge clk);
            mem_ack = 1'b0; mem_rdata = $urandom;
            chk("resp_done", {31'd0, done}, 32'd1);
            chk("resp_stall", {31'd0, stall}, 32'd0);
            chk("resp_req", {31'd0, mem_req}, 32'd0);
            chk("resp_fault", {31'd0, fault}, 32'd0);
            chk("resp_cause", {30'd0, fault_cause}, 32'd0);
            chk("resp_ld", load_data, e.ld);
        end
        valid_i = 1'b0; mr = 1'b0; mw = 1'b0;
        @(negedge clk);
        chk("post_done", {31'd0, done}, 32'd0);
        chk("post_ld_held", load_data, e.ld);
        chk("post_fault_held", {31'd0, fault}, {31'd0, e.fault});
    endtask

    initial begin
        int n;
        logic [1:0] kind;
        rst_n = 1'b0; valid_i = 1'b0; mr = 1'b0; mw = 1'b0; funct3 = 3'd0;
        address = 32'd0; rd2 = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Directed cases
        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 0);
        run_txn(1'b1, 1'b0, 3'b000, 32'h0000_0013, 32'd0, 32'h8011_2233, 1);
        run_txn(1'b1, 1'b0, 3'b100, 32'h0000_0013, 32'd0, 32'h8011_2233, 2);
        run_txn(1'b0, 1'b1, 3'b001, 32'h0000_0022, 32'h1234_ABCD, 32'hFFFF_FFFF, 0);
        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'd0, 32'd0, 0);
        run_txn(1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'd0, 32'd0, 0);
        run_txn(1'b0, 1'b1, 3'b100, 32'h0000_0003, 32'd0, 32'd0, 0);
        run_txn(1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'd0, 32'h8765_4321, 3);

        // Timeout: LH never acked
        @(negedge clk);
        valid_i = 1'b1; mr = 1'b1; mw = 1'b0; funct3 = 3'b001; address = 32'h0000_0100;
        @(negedge clk);
        n = 0;
        while (mem_req === 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("to_req_cycles", n, 32'd255);
        chk("to_done", {31'd0, done}, 32'd1);
        chk("to_fault", {31'd0, fault}, 32'd1);
        chk("to_cause", {30'd0, fault_cause}, 32'd3);
        valid_i = 1'b0; mr = 1'b0; mem_ack = 1'b1;
        @(negedge clk);
        chk("late_ack_done", {31'd0, done}, 32'd0);
        chk("late_ack_req", {31'd0, mem_req}, 32'd0);
        chk("late_ack_fault", {31'd0, fault}, 32'd1);
        chk("late_ack_cause", {30'd0, fault_cause}, 32'd3);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack_stall", {31'd0, stall}, 32'd0);

        // Reset during BUSY
        @(negedge clk);
        valid_i = 1'b1; mr = 1'b1; funct3 = 3'b010; address = 32'h0000_0040;
        @(negedge clk);
        chk("rst_busy_req", {31'd0, mem_req}, 32'd1);
        rst_n = 1'b0; valid_i = 1'b0; mr = 1'b0;
        @(negedge clk);
        chk_all_zero("rst_busy");
        rst_n = 1'b1;
        run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0044, 32'd0, 32'hCAFE_F00D, 1);

        // Randomized transactions
        for (int k = 0; k < 60; k++) begin
            kind = 2'($urandom_range(0, 2));
            run_txn(kind != 2'd1, kind != 2'd0, 3'($urandom_range(0, 7)), $urandom, $urandom,
                    $urandom, int'($urandom_range(0, 4)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
